// File: rtl/nios2_system_switch_pkg.sv
// ---------------------------------------------------------------------------
// nios2_system_switch_pkg
//
// Shared defaults and helpers for the slide-switch conditioning block that
// feeds the Nios II switch PIO.
//
//   SW_WIDTH_DEFAULT           : number of switch bits on the board (8)
//   SW_DEBOUNCE_CYCLES_DEFAULT : stable cycles needed to accept a new level
//                                (500000 = 10 ms at 50 MHz)
//   sw_cnt_width(cycles)       : width of the per-bit stability counter
// ---------------------------------------------------------------------------
package nios2_system_switch_pkg;

  localparam int SW_WIDTH_DEFAULT           = 8;
  localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 500000;

  // The counter only ever has to hold 0 .. cycles-1.
  function automatic int sw_cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/nios2_system_switch_debounce_bit.sv
// ---------------------------------------------------------------------------
// nios2_system_switch_debounce_bit
//
// One switch bit: two-flop synchroniser followed by a stability counter.
// A new level is accepted only after the synchronised input has disagreed
// with the current clean level for DEBOUNCE_CYCLES consecutive edges; any
// return to the clean level restarts the count from zero.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a change (>= 2)
//
// Ports
//   clk          in  : system clock
//   reset        in  : asynchronous, active-high reset
//   sw_raw       in  : asynchronous switch pin
//   sw_clean     out : debounced level (registered)
//   change_pulse out : one-cycle strobe on the edge sw_clean changes
//   change_next  out : combinational "sw_clean changes on the next edge",
//                      used by the parent to load edge-capture flags on the
//                      same edge as the pulse
// ---------------------------------------------------------------------------
module nios2_system_switch_debounce_bit
  import nios2_system_switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_clean,
  output logic change_pulse,
  output logic change_next
);

  localparam int                CNT_W    = sw_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             clean_p2;
  logic             pulse_p2;

  logic             mismatch;
  logic             accept;

  // Because the count restarts whenever the levels agree and is cleared on
  // acceptance, cnt_p2 never passes CNT_LAST and cannot wrap.
  always_comb begin
    mismatch = (sync_p1 != clean_p2);
    accept   = mismatch && (cnt_p2 == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt_p2   <= '0;
      clean_p2 <= 1'b0;
      pulse_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability filter on the asynchronous pin
      sync_p0  <= sw_raw;
      sync_p1  <= sync_p0;
      // p2: stability count, clean level and change strobe
      pulse_p2 <= accept;
      if (!mismatch) begin
        cnt_p2 <= '0;
      end else if (accept) begin
        clean_p2 <= sync_p1;
        cnt_p2   <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
    end
  end

  assign sw_clean     = clean_p2;
  assign change_pulse = pulse_p2;
  assign change_next  = accept;

endmodule

// File: rtl/nios2_system_switch_debounce.sv
// ---------------------------------------------------------------------------
// nios2_system_switch_debounce
//
// Conditions the raw slide-switch bank for the Nios II switch PIO. Every bit
// is synchronised and debounced independently; the clean vector drives the
// PIO in_port directly. Per-bit change strobes are always produced.
//
// Optional feature (macro SWITCH_DEBOUNCE_EDGE_CAPTURE_EN):
//   defined   : sticky per-bit edge_capture flags (set on any accepted change,
//               rising or falling; write-1-to-clear via edge_clear, set wins
//               over clear) and irq = OR of the flags.
//   undefined : edge_capture and irq are tied to 0, edge_clear is ignored and
//               no capture flops exist.
//
// Parameters
//   WIDTH           : number of switch bits
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a change (>= 2)
//
// Ports
//   clk          in  1     : system clock
//   reset        in  1     : asynchronous, active-high reset
//   sw_raw       in  WIDTH : asynchronous switch pins
//   sw_clean     out WIDTH : debounced level to PIO in_port
//   change_pulse out WIDTH : one-cycle strobe per bit on each accepted change
//   edge_clear   in  WIDTH : write-1-to-clear for edge_capture
//   edge_capture out WIDTH : sticky change flags
//   irq          out 1     : OR of edge_capture
// ---------------------------------------------------------------------------
module nios2_system_switch_debounce
  import nios2_system_switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH_DEFAULT,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] change_pulse,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  logic [WIDTH-1:0] change_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios2_system_switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .reset        (reset),
      .sw_raw       (sw_raw[i]),
      .sw_clean     (sw_clean[i]),
      .change_pulse (change_pulse[i]),
      .change_next  (change_next[i])
    );
  end

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN

  logic [WIDTH-1:0] capture_p3;

  // p3: sticky flags load on the same edge as change_pulse; OR-ing the set
  // term last makes a simultaneous set win over a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_p3 <= '0;
    end else begin
      capture_p3 <= (capture_p3 & ~edge_clear) | change_next;
    end
  end

  assign edge_capture = capture_p3;
  assign irq          = |capture_p3;

`else

  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{edge_clear, change_next};

  assign edge_capture = '0;
  assign irq          = 1'b0;

`endif

endmodule

// File: tb/tb_nios2_system_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_nios2_system_switch_debounce
//
// Directed scenarios followed by randomized switch activity, all compared
// cycle by cycle against a sliding-window reference model: a bit's clean
// level flips on an edge exactly when the last DEBOUNCE_CYCLES synchronised
// samples (raw delayed by two edges) all differ from it.
// ---------------------------------------------------------------------------
module tb_nios2_system_switch_debounce;

  localparam int W = 8;
  localparam int D = 4;

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] change_pulse;
  logic [W-1:0] edge_clear;
  logic [W-1:0] edge_capture;
  logic         irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios2_system_switch_debounce #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .sw_clean     (sw_clean),
    .change_pulse (change_pulse),
    .edge_clear   (edge_clear),
    .edge_capture (edge_capture),
    .irq          (irq)
  );

  // ---------------- reference model ----------------
  // hist[k] holds the raw vector seen k+1 edges ago (hist[0] = previous edge).
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_pulse;
  logic [W-1:0] m_cap;

  task automatic model_reset();
    for (int k = 0; k <= D; k++) hist[k] = '0;
    m_clean = '0;
    m_pulse = '0;
    m_cap   = '0;
  endtask

  // Bits whose clean level flips on the coming edge: the synchronised
  // samples of the last D edges (raw from 2..D+1 edges back) all disagree.
  function automatic logic [W-1:0] model_accept_next();
    logic [W-1:0] acc;
    acc = '1;
    for (int k = 1; k <= D; k++) acc &= (hist[k] ^ m_clean);
    return acc;
  endfunction

  task automatic model_edge();
    logic [W-1:0] acc;
    acc     = model_accept_next();
    m_pulse = acc;
    if (CAP_EN) m_cap = (m_cap & ~edge_clear) | acc;
    m_clean = m_clean ^ acc;
    for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = sw_raw;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string tag);
    checks++;
    assert (sw_clean === m_clean) else begin
      errors++;
      $error("FAIL %s sw_clean got=%h exp=%h", tag, sw_clean, m_clean);
    end
    checks++;
    assert (change_pulse === m_pulse) else begin
      errors++;
      $error("FAIL %s change_pulse got=%h exp=%h", tag, change_pulse, m_pulse);
    end
    checks++;
    assert (edge_capture === m_cap) else begin
      errors++;
      $error("FAIL %s edge_capture got=%h exp=%h", tag, edge_capture, m_cap);
    end
    checks++;
    assert (irq === (|m_cap)) else begin
      errors++;
      $error("FAIL %s irq got=%b exp=%b", tag, irq, |m_cap);
    end
  endtask

  task automatic expect8(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_int(string tag, int got, int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock edge: model follows the DUT unless reset is held, outputs are
  // sampled 1 ns after the edge, and the task returns on the falling edge
  // so the caller can drive the next inputs.
  task automatic step(string tag);
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check(tag);
    @(negedge clk);
  endtask

  // Counts edges until sw_clean[b] goes high (bounded).
  task automatic steps_until_high(string tag, int b, output int n);
    n = 0;
    do begin
      step(tag);
      n++;
    end while (!sw_clean[b] && n < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int           n;
    int           pulses0;
    logic [W-1:0] others;
    logic         glitch_seen;
    int           p;

    reset      = 1'b1;
    sw_raw     = 8'hFF;
    edge_clear = '0;
    model_reset();

    // Reset values with all switches high
    repeat (3) step("reset_hold");
    expect8("reset_clean", sw_clean, 8'h00);
    expect8("reset_pulse", change_pulse, 8'h00);
    expect8("reset_cap", edge_capture, 8'h00);

    // Power-up qualification: rise at the 6th edge after release
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step("powerup");
      if (i == 5) expect8("powerup_clean_e5", sw_clean, 8'h00);
      if (i == 6) begin
        expect8("powerup_clean_e6", sw_clean, 8'hFF);
        expect8("powerup_pulse_e6", change_pulse, 8'hFF);
      end
      if (i == 7) expect8("powerup_pulse_e7", change_pulse, 8'h00);
    end

    sw_raw = 8'h00;
    repeat (8) step("settle_low");
    expect8("settle_low_clean", sw_clean, 8'h00);

    // Clean step on bit 0
    sw_raw  = 8'h01;
    pulses0 = 0;
    others  = '0;
    for (int i = 0; i < 8; i++) begin
      step("clean_step");
      if (i == 4) expect8("clean_step_e4", sw_clean, 8'h00);
      if (i == 5) expect8("clean_step_e5", sw_clean, 8'h01);
      if (change_pulse[0]) pulses0++;
      others |= (change_pulse & 8'hFE);
    end
    expect_int("clean_step_pulse_count", pulses0, 1);
    expect8("clean_step_other_pulses", others, 8'h00);

    // Glitch on bit 3 shorter than the debounce window
    glitch_seen = 1'b0;
    sw_raw = 8'h09;
    repeat (3) begin
      step("glitch_hi");
      glitch_seen |= sw_clean[3] | change_pulse[3];
    end
    sw_raw = 8'h01;
    repeat (10) begin
      step("glitch_lo");
      glitch_seen |= sw_clean[3] | change_pulse[3];
    end
    expect_int("glitch_invisible", int'(glitch_seen), 0);
    expect8("glitch_clean", sw_clean, 8'h01);

    sw_raw = 8'h09;
    steps_until_high("hold_bit3", 3, n);
    expect_int("hold_bit3_latency", n, 6);
    repeat (4) step("hold_bit3_tail");

    // Edge capture and clear
    edge_clear = 8'hFF;
    step("cap_clear_all");
    edge_clear = 8'h00;
    sw_raw = 8'h88;
    repeat (7) step("cap_toggle");
    expect8("cap_81", edge_capture, CAP_EN ? 8'h81 : 8'h00);
    expect_int("cap_irq", int'(irq), CAP_EN ? 1 : 0);
    edge_clear = 8'h01;
    step("cap_clear0");
    edge_clear = 8'h00;
    expect8("cap_80", edge_capture, CAP_EN ? 8'h80 : 8'h00);

    // Clear bit 7 on exactly the edge a new bit-7 change is accepted
    sw_raw = 8'h08;
    n = 0;
    do begin
      edge_clear = model_accept_next()[7] ? 8'h80 : 8'h00;
      step("cap_setwins");
      n++;
    end while (!m_pulse[7] && n < 20);
    edge_clear = 8'h00;
    expect_int("cap_setwins_reached", n, 6);
    expect8("cap_setwins", edge_capture, CAP_EN ? 8'h80 : 8'h00);
    expect8("cap_setwins_clean", sw_clean, 8'h08);

    // Reset mid-count on bit 2
    sw_raw = 8'h0C;
    repeat (4) step("midrst_count");
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_async");
    expect8("midrst_clean", sw_clean, 8'h00);
    repeat (2) step("midrst_hold");
    reset = 1'b0;
    steps_until_high("midrst_requalify", 2, n);
    expect_int("midrst_latency", n, 6);

    // Randomized bouncing with random clears
    for (int seg = 0; seg < 20; seg++) begin
      p = int'($urandom_range(0, 3));
      repeat (20) begin
        for (int b = 0; b < W; b++)
          if (int'($urandom_range(0, 15)) < p) sw_raw[b] = ~sw_raw[b];
        edge_clear = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
        step("random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios2_system_switch_debounce.md
# nios2_system_switch_debounce

Conditions the raw slide-switch bank before it reaches the Nios II switch PIO. Each bit is double-flop synchronised into `clk`, then debounced with a per-bit stability counter; the clean vector drives the PIO `in_port` directly. The block also emits per-bit change strobes and, optionally, a sticky edge-capture register with an interrupt line.

## Interface
- `WIDTH`, 8: number of switch bits.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new level. Legal range is ≥ 2.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `sw_raw`  in  WIDTH: asynchronous switch pins.
- `sw_clean`  out  WIDTH: debounced level, wired to the PIO `in_port`.
- `change_pulse`  out  WIDTH: one-cycle strobe for each bit whose `sw_clean` changed on that edge.
- `edge_clear`  in  WIDTH: write-1-to-clear for `edge_capture`.
- `edge_capture`  out  WIDTH: sticky per-bit change flags.
- `irq`  out  1: OR of `edge_capture`.

## Operation
- **Synchroniser:** `sync1 <= sw_raw`, then `sync2 <= sync1`, per bit.
- **Per-bit counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES)`. On each rising edge:
  - `sync2 == sw_clean`: `cnt <= 0`.
  - `sync2 != sw_clean` and `cnt == DEBOUNCE_CYCLES-1`: `sw_clean <= sync2`, `cnt <= 0`, `change_pulse <= 1`.
  - Otherwise: `cnt <= cnt + 1`.
- `change_pulse` is registered and is 0 on every edge that does not update `sw_clean`.
- **Glitches:** any return of `sync2` to the `sw_clean` level before the count completes restarts the count from 0. A bounce shorter than `DEBOUNCE_CYCLES` is never visible.
- **Counter range:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- **Bit independence:** bits are fully independent. Multiple bits may pulse on the same edge.
- **Edge capture (when compiled in):**
  - `edge_capture[i] <= (edge_capture[i] & ~edge_clear[i]) | change_pulse_next[i]`.
  - Set and clear on the same edge: set wins.
  - Both rising and falling changes set the flag.
- **Reset:** asserting `reset` mid-count immediately zeroes all state. A held switch therefore re-qualifies from scratch after reset release.

## Timing
- **Reset values:** `sync1`, `sync2`, `sw_clean`, `cnt`, `change_pulse`, `edge_capture` and `irq` are all 0.
- **Latency:** if `sw_raw` changes before edge 0 and then holds:
  - `sync2` updates at edge 1.
  - `sw_clean` and `change_pulse` update at edge 1+`DEBOUNCE_CYCLES`.
  - `edge_capture` updates on that same edge.
  - `irq` is combinational from `edge_capture`.
- **Pulse width:** `change_pulse` is high for exactly one cycle per accepted change.
- **Reset at power-up:** a switch held at 1 through reset produces `sw_clean` rising, plus a `change_pulse`, `DEBOUNCE_CYCLES`+2 edges after reset deasserts.
- **Clear:** `edge_clear` takes effect on the next edge. `irq` drops in the same cycle that `edge_capture` clears.

## Configuration
- Macro: `SWITCH_DEBOUNCE_EDGE_CAPTURE_EN`.
- **Defined:** the `edge_capture` register and `irq` are implemented as described above.
- **Undefined:**
  - `edge_capture` and `irq` are tied to 0.
  - `edge_clear` is ignored.
  - No capture flops are synthesised.
  - All other behaviour is identical.

## Structure
- **Package `nios2_system_switch_pkg`:**
  - `SW_WIDTH_DEFAULT` = 8.
  - `SW_DEBOUNCE_CYCLES_DEFAULT` = 500000 (10 ms at 50 MHz).
  - Function `sw_cnt_width(cycles)` returning `$clog2(cycles)`.
- **Sub-module `nios2_system_switch_debounce_bit`:**
  - Contains the single-bit synchroniser, counter and pulse logic.
  - Instantiated WIDTH times via generate.
- **Top level:** holds the edge-capture logic and `irq`.

## Test plan
All scenarios use `WIDTH`=8 and `DEBOUNCE_CYCLES`=4.
- **Reset values:** assert `reset` with `sw_raw`=8'hFF → all outputs 0 during reset. Release reset → `sw_clean`=8'hFF and `change_pulse`=8'hFF for one cycle, at the 6th edge after release.
- **Clean step:** `sw_raw` 8'h00→8'h01 before edge 0 → `sw_clean`=8'h01 at edge 5. `change_pulse[0]` is high for exactly one cycle, and no other bit pulses.
- **Glitch rejection:** bit 3 high for 3 cycles, then low → `sw_clean` stays 8'h00 and there is no pulse. Then hold bit 3 high for 10 cycles → `sw_clean[3]` rises 5 edges after the first sampled edge.
- **Edge capture and clear:**
  - Toggle bits 0 and 7 → `edge_capture`=8'h81, `irq`=1.
  - Pulse `edge_clear`=8'h01 → `edge_capture`=8'h80.
  - Clear bit 7 on the same edge as a new bit-7 change → bit 7 stays 1.
- **Reset mid-count:** bit 2 high, assert `reset` after 2 counted cycles, release → `sw_clean[2]` rises only after a full 4-cycle qualification following resync.
- **Macro undefined:** repeat the edge-capture scenario → `edge_capture`=0 and `irq`=0 throughout, while `sw_clean` and `change_pulse` match the macro-defined run.
